// File: rtl/ps2_scancode_rx_pkg.sv
// ps2_scancode_rx_pkg: PS/2 scan-code constants and frame FSM encoding.
package ps2_scancode_rx_pkg;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_e;
endpackage

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: two-flop synchronizer and glitch filter for the PS/2 lines.
// Emits a one-cycle fallStrobe when the filtered clock goes low.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic PS2_CLK,
    input  logic PS2_DAT,
    output logic fallStrobe,
    output logic datSync
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_q, strobe_q;
    logic [CW-1:0] cnt_q;
    logic          differ, flip;
    assign differ     = clk_sync_q[1] != filt_q;
    assign flip       = differ && cnt_q == CW'(FILTER_LEN - 1);
    assign fallStrobe = strobe_q;
    assign datSync    = dat_sync_q[1];
    // Any sample matching the filtered level restarts the run of differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            cnt_q      <= '0;
            strobe_q   <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], PS2_DAT};
            cnt_q      <= (differ && !flip) ? cnt_q + CW'(1) : '0;
            filt_q     <= flip ? clk_sync_q[1] : filt_q;
            strobe_q   <= flip && !clk_sync_q[1];
        end
    end
endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 frame receiver plus make-code filter.
// Emits one codeValid per fresh key press; breaks, E0 keys and repeats are dropped.
module ps2_scancode_rx
    import ps2_scancode_rx_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] outCode,
    output logic       codeValid,
    output logic       frameErr
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    state_e        state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d, last_q, last_d, out_q, out_d;
    logic          par_q, par_d, brk_q, brk_d, ext_q, ext_d;
    logic          valid_q, valid_d, err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          strobe, dat, timeout, accept;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync (
        .clk        (clk),
        .reset      (reset),
        .PS2_CLK    (PS2_CLK),
        .PS2_DAT    (PS2_DAT),
        .fallStrobe (strobe),
        .datSync    (dat)
    );

    assign timeout   = state_q != ST_IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    assign accept    = strobe && state_q == ST_STOP && dat && par_q;
    assign outCode   = out_q;
    assign codeValid = valid_q;
    assign frameErr  = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            last_q  <= 8'h00;
            out_q   <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
            brk_q   <= brk_d;
            ext_q   <= ext_d;
            last_q  <= last_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // A strobe in the same cycle as the timeout takes priority.
    always_comb begin
        state_d = state_q;
        if (strobe) begin
            case (state_q)
                ST_IDLE:   state_d = dat ? ST_IDLE : ST_DATA;
                ST_DATA:   state_d = bit_q == 3'd7 ? ST_PARITY : ST_DATA;
                ST_PARITY: state_d = ST_STOP;
                default:   state_d = ST_IDLE;
            endcase
        end else if (timeout) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        brk_d   = brk_q;
        ext_d   = ext_q;
        last_d  = last_q;
        out_d   = out_q;
        valid_d = 1'b0;
        tmo_d   = (strobe || state_q == ST_IDLE) ? '0 : tmo_q + TW'(1);
        err_d   = strobe ? ((state_q == ST_IDLE && dat) || (state_q == ST_STOP && !accept)) : timeout;
        if (strobe) begin
            bit_d = state_q == ST_DATA ? bit_q + 3'd1 : 3'd0;
            if (state_q == ST_DATA) shift_d = {dat, shift_q[7:1]};
            if (state_q == ST_PARITY) par_d = ^{dat, shift_q};
        end
        if (accept) begin
            if (shift_q == PS2_BREAK) begin
                brk_d = 1'b1;
            end else if (shift_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (brk_q || ext_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                if (brk_q && shift_q == last_q) last_d = 8'h00;
            end else if (shift_q != last_q) begin
                out_d   = shift_q;
                last_d  = shift_q;
                valid_d = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: drives PS/2 frames and checks strobes against a key-press model.
module tb_ps2_scancode_rx;
    localparam int F    = 8;
    localparam int T    = 2000;
    localparam int HALF = 20;

    logic       clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1;
    logic [7:0] outCode;
    logic       codeValid, frameErr;

    ps2_scancode_rx #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .PS2_CLK   (ps2_clk),
        .PS2_DAT   (ps2_dat),
        .outCode   (outCode),
        .codeValid (codeValid),
        .frameErr  (frameErr)
    );

    always #5 clk = ~clk;

    int         checks = 0, failures = 0;
    logic [7:0] got_q[$], exp_q[$];
    int         err_cnt = 0, exp_err = 0, dbl_cnt = 0, hold_cnt = 0, saw75 = 0;
    logic       prev_v = 1'b0, prev_e = 1'b0;
    logic [7:0] prev_code = 8'h00;
    bit         m_brk, m_ext;
    logic [7:0] m_last;

    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
            prev_e = 1'b0;
            prev_code = 8'h00;
        end else begin
            if (codeValid) got_q.push_back(outCode);
            if (frameErr) err_cnt++;
            if ((codeValid && prev_v) || (frameErr && prev_e)) dbl_cnt++;
            if (!codeValid && outCode !== prev_code) hold_cnt++;
            if (outCode === 8'h75) saw75++;
            prev_v = codeValid;
            prev_e = frameErr;
            prev_code = outCode;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Key-press rules: F0/E0 arm a prefix, a prefixed code is swallowed, repeats are suppressed.
    task automatic model(input logic [7:0] c);
        if (c == 8'hF0) m_brk = 1;
        else if (c == 8'hE0) m_ext = 1;
        else if (m_brk || m_ext) begin
            if (m_brk && c == m_last) m_last = 8'h00;
            m_brk = 0;
            m_ext = 0;
        end else if (c != m_last) begin
            m_last = c;
            exp_q.push_back(c);
        end
    endtask

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = fr[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send(input logic [7:0] c, input bit bad_par = 0, input bit bad_stop = 0);
        send_bits({~bad_stop, (~^c) ^ bad_par, c, 1'b0}, 11);
        if (bad_par || bad_stop) exp_err++;
        else model(c);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_brk = 0;
        m_ext = 0;
        m_last = 8'h00;
        got_q.delete();
        exp_q.delete();
        err_cnt = 0;
        exp_err = 0;
        saw75 = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (outCode !== 8'h00) begin failures++; $display("FAIL reset_outCode got=%h exp=00", outCode); end
        checks++;
        if (codeValid !== 1'b0) begin failures++; $display("FAIL reset_codeValid got=%b exp=0", codeValid); end
        checks++;
        if (frameErr !== 1'b0) begin failures++; $display("FAIL reset_frameErr got=%b exp=0", frameErr); end
    endtask

    task automatic test_single();
        apply_reset();
        send(8'h1C);
        repeat (2 * HALF) @(negedge clk);
        checks++;
        if (got_q.size() !== 1) begin failures++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
        else begin
            checks++;
            if (got_q[0] !== 8'h1C) begin failures++; $display("FAIL single_code got=%h exp=1c", got_q[0]); end
        end
        checks++;
        if (err_cnt !== 0) begin failures++; $display("FAIL single_err got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_repeat();
        logic [7:0] seq[6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        apply_reset();
        foreach (seq[i]) send(seq[i]);
        repeat (2 * HALF) @(negedge clk);
        checks++;
        if (got_q.size() !== 2) begin failures++; $display("FAIL repeat_count got=%0d exp=2", got_q.size()); end
        else begin
            checks++;
            if (got_q[0] !== 8'h1C || got_q[1] !== 8'h1C) begin
                failures++;
                $display("FAIL repeat_codes got=%h,%h exp=1c,1c", got_q[0], got_q[1]);
            end
        end
    endtask

    task automatic test_ext_break();
        logic [7:0] seq[6] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h32};
        apply_reset();
        foreach (seq[i]) send(seq[i]);
        repeat (2 * HALF) @(negedge clk);
        checks++;
        if (got_q.size() !== 1) begin failures++; $display("FAIL ext_count got=%0d exp=1", got_q.size()); end
        else begin
            checks++;
            if (got_q[0] !== 8'h32) begin failures++; $display("FAIL ext_code got=%h exp=32", got_q[0]); end
        end
        checks++;
        if (saw75 !== 0) begin failures++; $display("FAIL ext_saw75 got=%0d exp=0", saw75); end
    endtask

    task automatic test_bad_parity();
        apply_reset();
        send(8'h1C, 1);
        send(8'h24);
        repeat (2 * HALF) @(negedge clk);
        checks++;
        if (err_cnt !== 1) begin failures++; $display("FAIL parity_err got=%0d exp=1", err_cnt); end
        checks++;
        if (got_q.size() !== 1) begin failures++; $display("FAIL parity_count got=%0d exp=1", got_q.size()); end
        checks++;
        if (outCode !== 8'h24) begin failures++; $display("FAIL parity_code got=%h exp=24", outCode); end
    endtask

    task automatic test_timeout();
        int at = -1;
        apply_reset();
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
        for (int i = 1; i <= T + F + 20; i++) begin
            @(negedge clk);
            if (frameErr) begin at = HALF + i; break; end
        end
        checks++;
        if (at !== F + T + 3) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d", at, F + T + 3); end
        @(negedge clk);
        checks++;
        if (frameErr !== 1'b0) begin failures++; $display("FAIL timeout_width got=%b exp=0", frameErr); end
        send(8'h2B);
        repeat (2 * HALF) @(negedge clk);
        checks++;
        if (got_q.size() !== 1 || outCode !== 8'h2B) begin
            failures++;
            $display("FAIL timeout_next got=%0d/%h exp=1/2b", got_q.size(), outCode);
        end
        checks++;
        if (err_cnt !== 1) begin failures++; $display("FAIL timeout_errcnt got=%0d exp=1", err_cnt); end
    endtask

    task automatic test_glitch_reset();
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            ps2_clk = 1'b0;
            repeat ($urandom_range(1, F - 1)) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (F + 4) @(negedge clk);
        end
        checks++;
        if (err_cnt !== 0 || got_q.size() !== 0) begin
            failures++;
            $display("FAIL glitch_strobe err=%0d codes=%0d exp=0/0", err_cnt, got_q.size());
        end
        send(8'h1C);
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (outCode !== 8'h00 || codeValid !== 1'b0 || frameErr !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h/%b/%b exp=00/0/0", outCode, codeValid, frameErr);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_brk = 0;
        m_ext = 0;
        m_last = 8'h00;
        repeat (2) @(negedge clk);
        send(8'h1C);
        repeat (2 * HALF) @(negedge clk);
        checks++;
        if (got_q.size() !== 2 || outCode !== 8'h1C) begin
            failures++;
            $display("FAIL midreset_next got=%0d/%h exp=2/1c", got_q.size(), outCode);
        end
        checks++;
        if (err_cnt !== 0) begin failures++; $display("FAIL midreset_err got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_back_to_back_random();
        logic [7:0] pool[8] = '{8'h1C, 8'h1C, 8'hF0, 8'hE0, 8'h32, 8'h24, 8'h75, 8'h1C};
        logic [7:0] c;
        apply_reset();
        dbl_cnt = 0;
        hold_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            c = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
            send(c, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
        end
        repeat (2 * HALF) @(negedge clk);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL random_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL random_code[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
            end
        end
        checks++;
        if (err_cnt !== exp_err) begin failures++; $display("FAIL random_err got=%0d exp=%0d", err_cnt, exp_err); end
        checks++;
        if (dbl_cnt !== 0) begin failures++; $display("FAIL strobe_width got=%0d exp=0", dbl_cnt); end
        checks++;
        if (hold_cnt !== 0) begin failures++; $display("FAIL outcode_hold got=%0d exp=0", hold_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_ext_break();
        test_bad_parity();
        test_timeout();
        test_glitch_reset();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

Receives the PS/2 keyboard serial stream and deserializes each 11-bit frame into an 8-bit scan code. Filters the result down to one strobe per fresh key press: break sequences, extended (E0) keys and typematic repeats are dropped. Sits directly upstream of the scan-code-to-letter decoder. Its `outCode` feeds the decoder's `inCode`, and `codeValid` tells the game FSM when to sample the decoded letter.

## Interface
- `FILTER_LEN`, 8: number of consecutive identical system-clock samples required before the synchronized PS2 clock level is accepted.
- `TIMEOUT_CYCLES`, 50000: idle system cycles (1 ms at 50 MHz) after which a partial frame is aborted.
- `clk` input 1: system clock, single clock domain.
- `reset` input 1: synchronous, active-high reset.
- `PS2_CLK` input 1: raw keyboard clock, asynchronous.
- `PS2_DAT` input 1: raw keyboard data, asynchronous.
- `outCode` output 8: last accepted make code. Held between strobes.
- `codeValid` output 1: one-cycle strobe; `outCode` is new this cycle.
- `frameErr` output 1: one-cycle strobe on parity, start, stop or timeout error.

## Operation
- **Input sync:** two-flop synchronizer on both PS2 lines. The filtered clock level changes only after `FILTER_LEN` equal samples. A falling edge of the filtered clock is a bit strobe, and `PS2_DAT` (synchronized) is sampled on that strobe.
- **Frame FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: strobe with data 0 -> DATA, bit count 0. Strobe with data 1 -> frameErr, stay IDLE.
  - DATA: shift in LSB first. After the 8th bit -> PARITY.
  - PARITY: check odd parity. Data bits plus parity bit must contain an odd number of ones. Store the pass/fail result -> STOP.
  - STOP: data 1 and parity ok -> frame accepted. Otherwise frameErr. Either way -> IDLE.
- **Timeout:** counter clears on every strobe and counts only while not in IDLE. Reaching `TIMEOUT_CYCLES - 1` aborts to IDLE and pulses frameErr.
- **Code filter:** runs only on accepted frames.
  - 0xF0: set `brk`.
  - 0xE0: set `ext`.
  - Other code with `brk` or `ext` set: clear both flags. If `brk` was set and the code equals `lastMake`, clear `lastMake` to 0x00. No strobe.
  - Other code with both flags clear: if the code differs from `lastMake`, load `outCode` and `lastMake` and pulse codeValid. If it equals `lastMake`, it is a typematic repeat and is suppressed.
- **Errored frames:** leave the filter state untouched.
- **Reset values:** `outCode` 0x00, codeValid 0, frameErr 0, FSM IDLE, `brk`/`ext` 0, `lastMake` 0x00, filtered clock 1, counters 0.

## Timing
- Strobe latency: 2 sync cycles plus `FILTER_LEN` cycles after the raw PS2_CLK falling edge.
- Output latency: `outCode`/codeValid/frameErr are registered and assert on the cycle after the stop-bit strobe. They stay high for exactly one cycle.
- Timeout frameErr asserts on the cycle after the counter reaches its terminal value.
- Back-to-back frames: the next start bit may arrive on the first strobe after the stop strobe; no dead time.
- Precedence: reset wins over everything. It aborts a frame mid-shift with no strobe, and the next frame is received normally. A timeout and a strobe in the same cycle: the strobe wins.

## Structure
- Shared package holds the PS/2 constants: `PS2_BREAK` = 8'hF0, `PS2_EXT` = 8'hE0.
- Shared package also holds the FSM state encoding.
- One sub-module: `ps2_sync_filter`, which does the synchronizer plus glitch filter and emits the `fallStrobe` and `datSync` signals.
- The FSM and the code filter stay in the top module.

## Test plan
- **Single press:** frame 0x1C (parity 0, stop 1) -> one codeValid, `outCode` = 0x1C, frameErr stays 0.
- **Press/release/repeat:** 1C, 1C, 1C, F0, 1C, 1C -> codeValid exactly twice, both with 0x1C: once for the first 1C, once after the release.
- **Extended and break:** E0 75, then E0 F0 75, then 0x32 -> single codeValid with 0x32, and `outCode` is never 0x75.
- **Bad parity:** 0x1C frame sent with parity 1 -> frameErr pulse, no codeValid. The following good 0x24 -> `outCode` = 0x24.
- **Timeout:** send 5 bits, then idle `TIMEOUT_CYCLES` -> frameErr one cycle after the terminal count. A following 0x2B frame decodes correctly.
- **Glitches and reset:** PS2_CLK glitches shorter than `FILTER_LEN` produce no bit strobe. Reset asserted mid-frame -> all outputs 0, no strobe, and the next 0x1C frame decodes correctly.
